// File: rtl/audio_i2s_port.sv
// Master-mode I2S codec port: BCLK/LRCK generation, one-pair playback buffer, stereo capture.
// Define I2S_LOOPBACK_EN to add a LOOPBACK input that feeds AUD_DACDAT back into the capture path.
`timescale 1ns/1ps
module audio_i2s_port #(
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_BITS  = 32,
  parameter int BCLK_DIV   = 4
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
`ifdef I2S_LOOPBACK_EN
  input  logic                  LOOPBACK,
`endif
  output logic                  AUD_BCLK,
  output logic                  AUD_LRCK,
  input  logic                  AUD_ADCDAT,
  output logic                  AUD_DACDAT,
  output logic [DATA_WIDTH-1:0] ADC_L,
  output logic [DATA_WIDTH-1:0] ADC_R,
  output logic                  ADC_VALID,
  input  logic [DATA_WIDTH-1:0] DAC_L,
  input  logic [DATA_WIDTH-1:0] DAC_R,
  input  logic                  DAC_VALID,
  output logic                  DAC_READY,
  output logic                  UNDERRUN
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int BIT_W      = $clog2(FRAME_BITS);
  localparam int DIV_W      = $clog2(BCLK_DIV);

  logic [DIV_W-1:0]      div_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [BIT_W-1:0]      bit_next;
  logic [BIT_W-1:0]      pos_cur;
  logic [BIT_W-1:0]      pos_next;
  logic                  div_tc;
  logic                  bclk_fall;
  logic                  bclk_rise;
  logic                  frame_start;
  logic                  tx_en;
  logic                  tx_right;
  logic                  tx_bit;
  logic                  rx_en;
  logic                  rx_right;
  logic                  cap_din;
  logic                  dac_xfer;
  logic                  buf_full;
  logic [DATA_WIDTH-1:0] buf_l, buf_r;
  logic [DATA_WIDTH-1:0] tx_l, tx_r;
  logic [DATA_WIDTH-1:0] cap_l, cap_r;

  function automatic logic [BIT_W-1:0] slot_pos(input logic [BIT_W-1:0] b);
    return (b >= BIT_W'(SLOT_BITS)) ? b - BIT_W'(SLOT_BITS) : b;
  endfunction

  assign div_tc      = (div_cnt == DIV_W'(BCLK_DIV - 1));
  assign bclk_fall   = div_tc & AUD_BCLK;
  assign bclk_rise   = div_tc & ~AUD_BCLK;
  assign frame_start = bclk_fall & (bit_cnt == BIT_W'(FRAME_BITS - 1));
  assign bit_next    = (bit_cnt == BIT_W'(FRAME_BITS - 1)) ? '0 : bit_cnt + 1'b1;

  // Output bit for the slot position entered on this fall; receive bit for the position now held.
  assign pos_next = slot_pos(bit_next);
  assign pos_cur  = slot_pos(bit_cnt);
  assign tx_en    = (pos_next != '0) && (pos_next <= BIT_W'(DATA_WIDTH));
  assign tx_right = (bit_next >= BIT_W'(SLOT_BITS));
  assign tx_bit   = tx_en & (tx_right ? tx_r[DATA_WIDTH-1] : tx_l[DATA_WIDTH-1]);
  assign rx_en    = (pos_cur != '0) && (pos_cur <= BIT_W'(DATA_WIDTH));
  assign rx_right = (bit_cnt >= BIT_W'(SLOT_BITS));

`ifdef I2S_LOOPBACK_EN
  assign cap_din = LOOPBACK ? AUD_DACDAT : AUD_ADCDAT;
`else
  assign cap_din = AUD_ADCDAT;
`endif

  assign DAC_READY = ~buf_full;
  assign dac_xfer  = DAC_VALID & ~buf_full;

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      div_cnt    <= '0;
      AUD_BCLK   <= 1'b0;
      bit_cnt    <= '0;
      AUD_LRCK   <= 1'b0;
      AUD_DACDAT <= 1'b0;
    end else begin
      div_cnt <= div_tc ? '0 : div_cnt + 1'b1;
      if (div_tc)
        AUD_BCLK <= ~AUD_BCLK;
      if (bclk_fall) begin
        bit_cnt    <= bit_next;
        AUD_LRCK   <= tx_right;
        AUD_DACDAT <= tx_bit;
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      cap_l <= '0;
      cap_r <= '0;
    end else if (bclk_rise && rx_en) begin
      if (rx_right)
        cap_r <= {cap_r[DATA_WIDTH-2:0], cap_din};
      else
        cap_l <= {cap_l[DATA_WIDTH-2:0], cap_din};
    end
  end

  // A pair offered on the frame-start cycle bypasses the empty buffer straight into transmit.
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      buf_full  <= 1'b0;
      buf_l     <= '0;
      buf_r     <= '0;
      tx_l      <= '0;
      tx_r      <= '0;
      ADC_L     <= '0;
      ADC_R     <= '0;
      ADC_VALID <= 1'b0;
      UNDERRUN  <= 1'b0;
    end else begin
      ADC_VALID <= 1'b0;
      UNDERRUN  <= 1'b0;
      if (frame_start) begin
        ADC_L     <= cap_l;
        ADC_R     <= cap_r;
        ADC_VALID <= 1'b1;
        if (buf_full) begin
          tx_l     <= buf_l;
          tx_r     <= buf_r;
          buf_full <= 1'b0;
        end else if (dac_xfer) begin
          tx_l <= DAC_L;
          tx_r <= DAC_R;
        end else begin
          tx_l     <= '0;
          tx_r     <= '0;
          UNDERRUN <= 1'b1;
        end
      end else begin
        if (dac_xfer) begin
          buf_l    <= DAC_L;
          buf_r    <= DAC_R;
          buf_full <= 1'b1;
        end
        if (bclk_fall && tx_en) begin
          if (tx_right)
            tx_r <= tx_r << 1;
          else
            tx_l <= tx_l << 1;
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_i2s_port.sv
// Bench for audio_i2s_port: per-frame vector table plus frame-start, mid-frame reset and loopback cases.
`timescale 1ns/1ps
module tb_audio_i2s_port;
  localparam int DW   = 24;
  localparam int SLOT = 32;

  logic          CLOCK = 1'b0;
  logic          RESET = 1'b0;
  logic          AUD_ADCDAT = 1'b0;
  logic          DAC_VALID = 1'b0;
  logic [DW-1:0] DAC_L = '0, DAC_R = '0;
  logic          AUD_BCLK, AUD_LRCK, AUD_DACDAT, ADC_VALID, DAC_READY, UNDERRUN;
  logic [DW-1:0] ADC_L, ADC_R;

  always #5 CLOCK = ~CLOCK;

  audio_i2s_port dut (
    .CLOCK(CLOCK), .RESET(RESET),
`ifdef I2S_LOOPBACK_EN
    .LOOPBACK(1'b0),
`endif
    .AUD_BCLK(AUD_BCLK), .AUD_LRCK(AUD_LRCK), .AUD_ADCDAT(AUD_ADCDAT), .AUD_DACDAT(AUD_DACDAT),
    .ADC_L(ADC_L), .ADC_R(ADC_R), .ADC_VALID(ADC_VALID),
    .DAC_L(DAC_L), .DAC_R(DAC_R), .DAC_VALID(DAC_VALID), .DAC_READY(DAC_READY),
    .UNDERRUN(UNDERRUN)
  );

`ifdef I2S_LOOPBACK_EN
  logic        lb_bclk, lb_lrck, lb_dacdat, lb_valid, lb_ready, lb_underrun;
  logic        lb_dv = 1'b0;
  logic [15:0] lb_adc_l, lb_adc_r;
  logic [15:0] lb_dl = '0, lb_dr = '0;
  audio_i2s_port #(.DATA_WIDTH(16), .SLOT_BITS(32)) lb (
    .CLOCK(CLOCK), .RESET(RESET), .LOOPBACK(1'b1),
    .AUD_BCLK(lb_bclk), .AUD_LRCK(lb_lrck), .AUD_ADCDAT(1'b0), .AUD_DACDAT(lb_dacdat),
    .ADC_L(lb_adc_l), .ADC_R(lb_adc_r), .ADC_VALID(lb_valid),
    .DAC_L(lb_dl), .DAC_R(lb_dr), .DAC_VALID(lb_dv), .DAC_READY(lb_ready),
    .UNDERRUN(lb_underrun)
  );
`endif

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Codec / line monitor, sampled 1 ns after each rising CLOCK edge.
  int            tb_bit, cyc_fall, frame_cyc, frame_cnt = 0, m_pos;
  int            stray, off_pulse, lrck_err = 0, period_err = 0, rst_valid = 0;
  int            last_stray, last_off, last_frame_cyc;
  logic          prev_bclk, m_fall, m_wrap;
  logic [DW-1:0] codec_l = '0, codec_r = '0, csh_l, csh_r, seen_l, seen_r;
  logic [DW-1:0] last_seen_l, last_seen_r, wrap_adc_l, wrap_adc_r;
  logic          wrap_valid, wrap_underrun;

  always @(posedge CLOCK) begin
    #1;
    if (!RESET) begin
      tb_bit = 0; prev_bclk = 1'b0; cyc_fall = 0; frame_cyc = 0;
      seen_l = '0; seen_r = '0; stray = 0; off_pulse = 0; AUD_ADCDAT = 1'b0;
      if (ADC_VALID || UNDERRUN) rst_valid++;
    end else begin
      cyc_fall++;
      frame_cyc++;
      m_fall = prev_bclk && !AUD_BCLK;
      prev_bclk = AUD_BCLK;
      m_wrap = m_fall && (tb_bit == 2*SLOT-1);
      if ((ADC_VALID || UNDERRUN) && !m_wrap) off_pulse++;
      if (m_fall) begin
        if (cyc_fall != 8) period_err++;
        cyc_fall = 0;
        if (m_wrap) begin
          last_seen_l = seen_l; last_seen_r = seen_r; last_stray = stray;
          last_off = off_pulse; last_frame_cyc = frame_cyc;
          wrap_valid = ADC_VALID; wrap_underrun = UNDERRUN;
          wrap_adc_l = ADC_L; wrap_adc_r = ADC_R;
          seen_l = '0; seen_r = '0; stray = 0; off_pulse = 0; frame_cyc = 0;
          tb_bit = 0;
          frame_cnt++;
        end else begin
          tb_bit++;
        end
        if (AUD_LRCK !== (tb_bit >= SLOT)) lrck_err++;
        m_pos = tb_bit % SLOT;
        if (m_pos == 1) begin
          if (tb_bit >= SLOT) csh_r = codec_r; else csh_l = codec_l;
        end
        if (m_pos >= 1 && m_pos <= DW) begin
          if (tb_bit >= SLOT) begin
            seen_r = {seen_r[DW-2:0], AUD_DACDAT};
            AUD_ADCDAT = csh_r[DW-1];
            csh_r = csh_r << 1;
          end else begin
            seen_l = {seen_l[DW-2:0], AUD_DACDAT};
            AUD_ADCDAT = csh_l[DW-1];
            csh_l = csh_l << 1;
          end
        end else begin
          if (AUD_DACDAT !== 1'b0) stray++;
          AUD_ADCDAT = 1'b0;
        end
      end
    end
  end

  task automatic dac_write(input logic [DW-1:0] l, input logic [DW-1:0] r);
    int n = 0;
    @(negedge CLOCK);
    DAC_L = l; DAC_R = r; DAC_VALID = 1'b1;
    while (!DAC_READY && n < 1000) begin
      @(negedge CLOCK);
      n++;
    end
    @(negedge CLOCK);
    DAC_VALID = 1'b0;
    chk("dac_accept", 32'(n < 1000), 32'd1);
  endtask

  task automatic wait_frame();
    int fc = frame_cnt;
    int n = 0;
    while (frame_cnt == fc && n < 1200) begin
      @(negedge CLOCK);
      n++;
    end
    chk("frame_wait", 32'(frame_cnt != fc), 32'd1);
  endtask

  task automatic frame_checks(input string tag, input logic [DW-1:0] al, input logic [DW-1:0] ar,
                              input logic und, input logic [DW-1:0] sl, input logic [DW-1:0] sr);
    chk({tag, "_adc_valid"}, 32'(wrap_valid), 32'd1);
    chk({tag, "_adc_l"}, 32'(wrap_adc_l), 32'(al));
    chk({tag, "_adc_r"}, 32'(wrap_adc_r), 32'(ar));
    chk({tag, "_underrun"}, 32'(wrap_underrun), 32'(und));
    chk({tag, "_dacdat_l"}, 32'(last_seen_l), 32'(sl));
    chk({tag, "_dacdat_r"}, 32'(last_seen_r), 32'(sr));
    chk({tag, "_dacdat_stray"}, 32'(last_stray), 32'd0);
    chk({tag, "_extra_pulses"}, 32'(last_off), 32'd0);
    chk({tag, "_frame_len"}, 32'(last_frame_cyc), 32'd512);
  endtask

  typedef struct {
    bit            wr;
    logic [DW-1:0] dl, dr, al, ar;
  } vec_t;

  vec_t          vt[6];
  logic [DW-1:0] exp_sl, exp_sr;

  initial begin
    vt[0] = '{1'b1, 24'hA5A5A5, 24'h5A5A5A, 24'h123456, 24'hFEDCBA};
    vt[1] = '{1'b0, 24'h000000, 24'h000000, 24'h000001, 24'h800000};
    vt[2] = '{1'b0, 24'h000000, 24'h000000, 24'hFFFFFF, 24'h000000};
    vt[3] = '{1'b1, 24'h800001, 24'h7FFFFE, 24'hABCDEF, 24'h555555};
    vt[4] = '{1'b1, 24'hFFFFFF, 24'h000001, 24'h0F0F0F, 24'hF0F0F0};
    vt[5] = '{1'b0, 24'h000000, 24'h000000, 24'h000000, 24'hC00003};

    RESET = 1'b0;
    repeat (5) @(negedge CLOCK);
    chk("rst_bclk", 32'(AUD_BCLK), 32'd0);
    chk("rst_lrck", 32'(AUD_LRCK), 32'd0);
    chk("rst_dacdat", 32'(AUD_DACDAT), 32'd0);
    chk("rst_adc_l", 32'(ADC_L), 32'd0);
    chk("rst_adc_r", 32'(ADC_R), 32'd0);
    chk("rst_adc_valid", 32'(ADC_VALID), 32'd0);
    chk("rst_underrun", 32'(UNDERRUN), 32'd0);
    chk("rst_dac_ready", 32'(DAC_READY), 32'd1);
    codec_l = vt[0].al; codec_r = vt[0].ar;
    RESET = 1'b1;

    exp_sl = '0; exp_sr = '0;
    for (int k = 0; k < 6; k++) begin
      codec_l = vt[k].al; codec_r = vt[k].ar;
      if (vt[k].wr) begin
        dac_write(vt[k].dl, vt[k].dr);
        chk("buf_full_ready_low", 32'(DAC_READY), 32'd0);
      end
      wait_frame();
      frame_checks($sformatf("vec%0d", k), vt[k].al, vt[k].ar, !vt[k].wr, exp_sl, exp_sr);
      exp_sl = vt[k].wr ? vt[k].dl : '0;
      exp_sr = vt[k].wr ? vt[k].dr : '0;
    end

    // Pair offered exactly on the frame-start cycle with the buffer empty.
    begin
      int n = 0;
      codec_l = 24'h00FF00; codec_r = 24'h0000FF;
      @(negedge CLOCK);
      while (!(tb_bit == 2*SLOT-1 && cyc_fall == 7) && n < 1200) begin
        @(negedge CLOCK);
        n++;
      end
      chk("fs_align", 32'(n < 1200), 32'd1);
      chk("fs_ready_before", 32'(DAC_READY), 32'd1);
      DAC_L = 24'h3C3C3C; DAC_R = 24'hC3C3C3; DAC_VALID = 1'b1;
      @(negedge CLOCK);
      DAC_VALID = 1'b0;
      chk("fs_ready_after", 32'(DAC_READY), 32'd1);
      chk("fs_underrun", 32'(wrap_underrun), 32'd0);
      chk("fs_wrap_seen", 32'(frame_cnt), 32'd7);
      codec_l = 24'h00FF00; codec_r = 24'h0000FF;
      wait_frame();
      frame_checks("fs_next", 24'h00FF00, 24'h0000FF, 1'b1, 24'h3C3C3C, 24'hC3C3C3);
    end

    // Reset in the middle of a frame with a buffered pair and a partial capture.
    begin
      int n = 0;
      codec_l = 24'h13579B; codec_r = 24'h2468AC;
      dac_write(24'h111111, 24'h222222);
      while (tb_bit != 40 && n < 1200) begin
        @(negedge CLOCK);
        n++;
      end
      chk("mid_align", 32'(n < 1200), 32'd1);
      RESET = 1'b0;
      repeat (5) @(negedge CLOCK);
      chk("mid_rst_bclk", 32'(AUD_BCLK), 32'd0);
      chk("mid_rst_lrck", 32'(AUD_LRCK), 32'd0);
      chk("mid_rst_adc_l", 32'(ADC_L), 32'd0);
      chk("mid_rst_ready", 32'(DAC_READY), 32'd1);
      RESET = 1'b1;
      wait_frame();
      frame_checks("after_rst", 24'h13579B, 24'h2468AC, 1'b1, 24'h0, 24'h0);
    end

`ifdef I2S_LOOPBACK_EN
    begin
      int n = 0;
      int pulses = 0;
      while (!lb_valid && n < 1200) begin
        @(negedge CLOCK);
        n++;
      end
      @(negedge CLOCK);
      lb_dl = 16'h8001; lb_dr = 16'h7FFE; lb_dv = 1'b1;
      chk("lb_ready", 32'(lb_ready), 32'd1);
      @(negedge CLOCK);
      lb_dv = 1'b0;
      n = 0;
      while (pulses < 2 && n < 1200) begin
        @(negedge CLOCK);
        n++;
        if (lb_valid) pulses++;
      end
      chk("lb_pulses", 32'(pulses), 32'd2);
      chk("lb_adc_l", 32'(lb_adc_l), 32'h8001);
      chk("lb_adc_r", 32'(lb_adc_r), 32'h7FFE);
    end
`endif

    chk("lrck_errors", 32'(lrck_err), 32'd0);
    chk("bclk_period_errors", 32'(period_err), 32'd0);
    chk("pulses_in_reset", 32'(rst_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
